popcount_sched: RTL

Round-robin scheduler that shares one 125-bit popcount adder (`popadd125`, instantiated internally) among `NREQ` requesters. Each requester submits a multi-beat job: a stream of `LEN`-bit vectors terminated by a `last` flag. The block locks the adder to one requester for the whole job and accumulates the per-beat counts into a total. It then returns the total, tagged with the requester id, over a valid/ready result port. It sits between the feature-vector producers and the downstream score logic.

---
 rtl/popcount_sched.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/popcount_sched.sv
// rtl/popcount_sched.sv - round-robin scheduler sharing one popcount adder across multi-beat jobs
// Locks the adder to one requester per job and returns the accumulated total over a valid/ready port.

module popadd125 #(
  parameter int W  = 125,
  parameter int CW = $clog2(W)
) (
  input  logic [W-1:0]  bits,
  output logic [CW-1:0] cnt
);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < W; i++) begin
      cnt = cnt + {{(CW-1){1'b0}}, bits[i]};
    end
  end

endmodule

module popcount_sched #(
  parameter int LEN      = 125,
  parameter int NREQ     = 4,
  parameter int MAXBEATS = 16,
  parameter int CW       = $clog2(LEN),
  parameter int IW       = $clog2(NREQ),
  parameter int BW       = $clog2(MAXBEATS + 1),
  parameter int AW       = $clog2(LEN * MAXBEATS + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_last,
  input  logic [NREQ*LEN-1:0]  req_bits,
  output logic [NREQ-1:0]      req_ready,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [IW-1:0]        res_id,
  output logic [AW-1:0]        res_sum,
  output logic [BW-1:0]        res_beats,
  output logic                 res_trunc
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DRAIN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   grant_q, grant_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [BW-1:0]   beats_q, beats_d;
  logic            trunc_q, trunc_d;
  logic            stg_v_q, stg_v_d;
  logic [LEN-1:0]  stg_bits_q, stg_bits_d;
  logic [NREQ-1:0] ready_q, ready_d;
  logic            res_valid_q, res_valid_d;

  logic [CW-1:0]   cnt;
  logic [LEN-1:0]  grant_bits;
  logic            grant_valid;
  logic            grant_last;
  logic            accept;
  logic            found;
  logic [IW-1:0]   pick;
  logic [IW-1:0]   rr_idx;

  popadd125 #(.W(LEN), .CW(CW)) u_popadd (
    .bits (stg_bits_q),
    .cnt  (cnt)
  );

  always_comb begin
    grant_bits  = req_bits[int'(grant_q)*LEN +: LEN];
    grant_valid = req_valid[grant_q];
    grant_last  = req_last[grant_q];
    accept      = grant_valid & ready_q[grant_q];
  end

  // First valid requester at or after ptr, searching upward with wrap.
  always_comb begin
    found  = 1'b0;
    pick   = '0;
    rr_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      rr_idx = IW'((int'(ptr_q) + i) % NREQ);
      if (!found && req_valid[rr_idx]) begin
        found = 1'b1;
        pick  = rr_idx;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    beats_d    = beats_q;
    trunc_d    = trunc_q;
    stg_v_d    = 1'b0;
    stg_bits_d = stg_bits_q;
    acc_d      = stg_v_q ? (acc_q + {{(AW-CW){1'b0}}, cnt}) : acc_q;

    case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d = pick;
          acc_d   = '0;
          beats_d = '0;
          trunc_d = 1'b0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (accept) begin
          stg_v_d    = 1'b1;
          stg_bits_d = grant_bits;
          beats_d    = beats_q + BW'(1);
          if (grant_last) begin
            state_d = S_DRAIN;
          end else if (beats_d == BW'(MAXBEATS)) begin
            state_d = S_DRAIN;
            trunc_d = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        if (res_valid_q && res_ready) begin
          ptr_d   = (grant_q == IW'(NREQ - 1)) ? '0 : grant_q + IW'(1);
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Handshake outputs are registered from the next state so they line up with it.
    ready_d     = (state_d == S_BUSY) ? (NREQ'(1) << grant_d) : '0;
    res_valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      acc_q       <= '0;
      beats_q     <= '0;
      trunc_q     <= 1'b0;
      stg_v_q     <= 1'b0;
      stg_bits_q  <= '0;
      ready_q     <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      acc_q       <= acc_d;
      beats_q     <= beats_d;
      trunc_q     <= trunc_d;
      stg_v_q     <= stg_v_d;
      stg_bits_q  <= stg_bits_d;
      ready_q     <= ready_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign req_ready = ready_q;
  assign res_valid = res_valid_q;
  assign res_id    = grant_q;
  assign res_sum   = acc_q;
  assign res_beats = beats_q;
  assign res_trunc = trunc_q;

endmodule
